// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_DELIVER = 3'd5
    } uart_rx_state_e;

    localparam int TICKS_MIN     = 4;
    localparam int TICKS_MAX     = 65535;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit tick counter and 3-tap majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int TicksPerBaud = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_ni,
    input  logic run_i,
    output logic rxs_o,
    output logic sample_stb_o,
    output logic bit_value_o,
    output logic wrap_stb_o
);
    localparam int TW = $clog2(TicksPerBaud);
    localparam logic [TW-1:0] MID_M1 = TW'(TicksPerBaud / 2 - 1);
    localparam logic [TW-1:0] MID    = TW'(TicksPerBaud / 2);
    localparam logic [TW-1:0] MID_P1 = TW'(TicksPerBaud / 2 + 1);
    localparam logic [TW-1:0] LAST   = TW'(TicksPerBaud - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          tap0_q, tap0_d;
    logic          tap1_q, tap1_d;
    logic [TW-1:0] tick_q, tick_d;

    // Tick counter is held at 0 whenever the receiver is not inside a frame.
    always_comb begin
        s1_d   = rx_ni;
        s2_d   = s1_q;
        tap0_d = tap0_q;
        tap1_d = tap1_q;
        tick_d = '0;
        if (run_i) begin
            tick_d = (tick_q == LAST) ? '0 : tick_q + TW'(1);
            if (tick_q == MID_M1) tap0_d = s2_q;
            if (tick_q == MID)    tap1_d = s2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            tap0_q <= 1'b1;
            tap1_q <= 1'b1;
            tick_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            tap0_q <= tap0_d;
            tap1_q <= tap1_d;
            tick_q <= tick_d;
        end
    end

    assign rxs_o        = s2_q;
    assign sample_stb_o = run_i && (tick_q == MID_P1);
    assign wrap_stb_o   = run_i && (tick_q == LAST);
    assign bit_value_o  = (tap0_q & tap1_q) | (tap0_q & s2_q) | (tap1_q & s2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: frame FSM, LSB-first shifter and one-entry valid/ready output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int TicksPerBaud = 16,
    parameter int DataBits     = 8,
    parameter int ParityMode   = 0,
    parameter int StopBits     = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                uart_rx_ni,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_parity_err_o,
    output logic                rx_frame_err_o,
    output logic                rx_overrun_o
);
    localparam int      BW     = $clog2(DataBits + 1);
    localparam parity_e PARITY = parity_e'(ParityMode[1:0]);

    if (TicksPerBaud < TICKS_MIN || TicksPerBaud > TICKS_MAX) begin : g_bad_ticks
        $error("uart_rx_cfg: TicksPerBaud out of range 4..65535");
    end
    if (DataBits < DATA_BITS_MIN || DataBits > DATA_BITS_MAX) begin : g_bad_data
        $error("uart_rx_cfg: DataBits out of range 5..9");
    end
    if (ParityMode < 0 || ParityMode > 2) begin : g_bad_parity
        $error("uart_rx_cfg: ParityMode must be 0, 1 or 2");
    end
    if (StopBits < STOP_BITS_MIN || StopBits > STOP_BITS_MAX) begin : g_bad_stop
        $error("uart_rx_cfg: StopBits must be 1 or 2");
    end

    uart_rx_state_e      state_q, state_d;
    logic                armed_q, armed_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                valid_q, valid_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                perr_out_q, perr_out_d;
    logic                ferr_out_q, ferr_out_d;
    logic                overrun_q, overrun_d;

    logic run, rxs, sample_stb, bit_value, wrap_stb;

    assign run = (state_q == ST_START) || (state_q == ST_DATA) ||
                 (state_q == ST_PARITY) || (state_q == ST_STOP);

    uart_rx_sampler #(
        .TicksPerBaud(TicksPerBaud)
    ) u_sampler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_ni       (uart_rx_ni),
        .run_i       (run),
        .rxs_o       (rxs),
        .sample_stb_o(sample_stb),
        .bit_value_o (bit_value),
        .wrap_stb_o  (wrap_stb)
    );

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        case (state_q)
            ST_IDLE: begin
                // After a framing error the line must be seen idle before a new start is accepted.
                if (!armed_q) begin
                    armed_d = rxs;
                end else if (!rxs) begin
                    state_d    = ST_START;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_START: begin
                if (sample_stb && bit_value) state_d = ST_IDLE;
                else if (wrap_stb)           state_d = ST_DATA;
            end
            ST_DATA: begin
                if (sample_stb) begin
                    shift_d   = {bit_value, shift_q[DataBits-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
                if (wrap_stb && (bit_cnt_d == BW'(DataBits))) begin
                    bit_cnt_d = '0;
                    state_d   = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (sample_stb) perr_d = ((^shift_q) ^ bit_value) != (PARITY == PARITY_ODD);
                if (wrap_stb)   state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leaving at the centre of the last stop bit gives half a bit of slack for the next start.
                if (sample_stb) begin
                    if (!bit_value) ferr_d = 1'b1;
                    if (stop_cnt_q == 1'(StopBits - 1)) state_d = ST_DELIVER;
                    else                                 stop_cnt_d = 1'b1;
                end
            end
            ST_DELIVER: begin
                state_d = ST_IDLE;
                armed_d = !ferr_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop in the same cycle as DELIVER frees the slot, so that case loads rather than overruns.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
        if (state_q == ST_DELIVER) begin
            if (!valid_q || rx_ready_i) begin
                valid_d    = 1'b1;
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_valid_o      = valid_q;
    assign rx_data_o       = data_q;
    assign rx_parity_err_o = perr_out_q;
    assign rx_frame_err_o  = ferr_out_q;
    assign rx_overrun_o    = overrun_q;

endmodule
